// File: rtl/encoder_tracker.sv
// Encoder step tracker: absolute position, per-window velocity and motion state.
// Optional build macro ENC_POS_SATURATE_EN clamps position at the signed range and drives at_limit.
module encoder_tracker #(
  parameter int POS_WIDTH     = 16,
  parameter int VEL_WIDTH     = 8,
  parameter int WINDOW        = 1000,
  parameter int STALL_WINDOWS = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 is_cw,
  input  logic                 is_ccw,
  input  logic                 load,
  input  logic [POS_WIDTH-1:0] load_value,
  output logic [POS_WIDTH-1:0] position,
  output logic [VEL_WIDTH-1:0] velocity,
  output logic                 vel_valid,
  output logic [1:0]           state,
  output logic                 illegal,
  output logic                 at_limit
);

  localparam int WIN_W   = $clog2(WINDOW);
  localparam int STALL_W = $clog2(STALL_WINDOWS + 1);

  localparam logic [WIN_W-1:0]     WIN_LAST   = WIN_W'(WINDOW - 1);
  localparam logic [WIN_W-1:0]     WIN_ONE    = WIN_W'(1);
  localparam logic [STALL_W-1:0]   STALL_LAST = STALL_W'(STALL_WINDOWS - 1);
  localparam logic [STALL_W-1:0]   STALL_ONE  = STALL_W'(1);
  localparam logic [POS_WIDTH-1:0] POS_ONE    = POS_WIDTH'(1);
  localparam logic [POS_WIDTH-1:0] POS_MAX    = {1'b0, {(POS_WIDTH-1){1'b1}}};
  localparam logic [POS_WIDTH-1:0] POS_MIN    = {1'b1, {(POS_WIDTH-1){1'b0}}};
  localparam logic [VEL_WIDTH:0]   ACC_ONE    = (VEL_WIDTH+1)'(1);
  localparam logic [VEL_WIDTH-1:0] VEL_MAX    = {1'b0, {(VEL_WIDTH-1){1'b1}}};
  localparam logic [VEL_WIDTH-1:0] VEL_MIN    = {1'b1, {(VEL_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE    = 2'b00,
    S_CW      = 2'b01,
    S_CCW     = 2'b10,
    S_STALLED = 2'b11
  } state_t;

  state_t               r_state;
  logic [POS_WIDTH-1:0] r_position;
  logic [VEL_WIDTH-1:0] r_velocity;
  logic [VEL_WIDTH-1:0] r_acc;
  logic                 r_vel_valid;
  logic                 r_illegal;
  logic [WIN_W-1:0]     r_win;
  logic [STALL_W-1:0]   r_stall_cnt;
  logic                 r_step_seen;

  logic                 w_up;
  logic                 w_dn;
  logic                 w_win_end;
  logic                 w_seen_now;
  logic [POS_WIDTH-1:0] w_pos_next;
  logic [VEL_WIDTH:0]   w_acc_ext;
  logic [VEL_WIDTH-1:0] w_acc_sat;

  // Both strobes together is a decoder fault, not a step in either direction.
  assign w_up       = is_cw & ~is_ccw;
  assign w_dn       = is_ccw & ~is_cw;
  assign w_win_end  = (r_win == WIN_LAST);
  assign w_seen_now = r_step_seen | w_up | w_dn;

  always_comb begin
    w_pos_next = r_position;
    if (load) begin
      w_pos_next = load_value;
    end else if (w_up) begin
`ifdef ENC_POS_SATURATE_EN
      if (r_position != POS_MAX) w_pos_next = r_position + POS_ONE;
`else
      w_pos_next = r_position + POS_ONE;
`endif
    end else if (w_dn) begin
`ifdef ENC_POS_SATURATE_EN
      if (r_position != POS_MIN) w_pos_next = r_position - POS_ONE;
`else
      w_pos_next = r_position - POS_ONE;
`endif
    end
  end

  // One guard bit above the accumulator exposes signed overflow for clamping.
  always_comb begin
    w_acc_ext = {r_acc[VEL_WIDTH-1], r_acc};
    if (w_up)      w_acc_ext = w_acc_ext + ACC_ONE;
    else if (w_dn) w_acc_ext = w_acc_ext - ACC_ONE;
    case (w_acc_ext[VEL_WIDTH:VEL_WIDTH-1])
      2'b01:   w_acc_sat = VEL_MAX;
      2'b10:   w_acc_sat = VEL_MIN;
      default: w_acc_sat = w_acc_ext[VEL_WIDTH-1:0];
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_position  <= '0;
      r_velocity  <= '0;
      r_acc       <= '0;
      r_vel_valid <= 1'b0;
      r_illegal   <= 1'b0;
      r_win       <= '0;
      r_step_seen <= 1'b0;
    end else begin
      r_position <= w_pos_next;
      r_illegal  <= is_cw & is_ccw;
      if (w_win_end) begin
        r_win       <= '0;
        r_velocity  <= w_acc_sat;
        r_vel_valid <= 1'b1;
        r_acc       <= '0;
        r_step_seen <= 1'b0;
      end else begin
        r_win       <= r_win + WIN_ONE;
        r_acc       <= w_acc_sat;
        r_vel_valid <= 1'b0;
        r_step_seen <= w_seen_now;
      end
    end
  end

  // A step in the current cycle overrides any stall decision made at window end.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_stall_cnt <= '0;
    end else begin
      if (w_win_end) begin
        if (w_seen_now || (r_state != S_CW && r_state != S_CCW)) begin
          r_stall_cnt <= '0;
        end else if (r_stall_cnt == STALL_LAST) begin
          r_stall_cnt <= '0;
          r_state     <= S_STALLED;
        end else begin
          r_stall_cnt <= r_stall_cnt + STALL_ONE;
        end
      end
      if (w_up)      r_state <= S_CW;
      else if (w_dn) r_state <= S_CCW;
    end
  end

`ifdef ENC_POS_SATURATE_EN
  logic r_at_limit;

  always_ff @(posedge clock) begin
    if (reset) r_at_limit <= 1'b0;
    else       r_at_limit <= (w_pos_next == POS_MAX) || (w_pos_next == POS_MIN);
  end

  assign at_limit = r_at_limit;
`else
  assign at_limit = 1'b0;
`endif

  assign position  = r_position;
  assign velocity  = r_velocity;
  assign vel_valid = r_vel_valid;
  assign state     = r_state;
  assign illegal   = r_illegal;

endmodule

// File: tb/tb_encoder_tracker.sv
// Self-checking bench for encoder_tracker: hand-derived vector table plus a
// cycle-level reference model feeding a scoreboard queue.
module tb_encoder_tracker;
  localparam int PW   = 8;
  localparam int VW   = 8;
  localparam int WIN  = 10;
  localparam int SW   = 2;
  localparam int PMAX = 127;
  localparam int PMIN = -128;
  localparam bit H    = 1'b1;
  localparam bit L    = 1'b0;
`ifdef ENC_POS_SATURATE_EN
  localparam bit SAT  = 1'b1;
`else
  localparam bit SAT  = 1'b0;
`endif

  logic          clock = 1'b0;
  logic          reset;
  logic          is_cw;
  logic          is_ccw;
  logic          load;
  logic [PW-1:0] load_value;
  logic [PW-1:0] position;
  logic [VW-1:0] velocity;
  logic          vel_valid;
  logic [1:0]    state;
  logic          illegal;
  logic          at_limit;

  encoder_tracker #(
    .POS_WIDTH(PW), .VEL_WIDTH(VW), .WINDOW(WIN), .STALL_WINDOWS(SW)
  ) dut (
    .clock(clock), .reset(reset), .is_cw(is_cw), .is_ccw(is_ccw),
    .load(load), .load_value(load_value), .position(position),
    .velocity(velocity), .vel_valid(vel_valid), .state(state),
    .illegal(illegal), .at_limit(at_limit)
  );

  always #5 clock = ~clock;

  typedef struct {
    bit cw; bit ccw; bit ld; int ldv;
    int pos; int st; int ill; int vel; int vv;
  } vec_t;

  typedef struct {
    int pos; int vel; int vv; int st; int ill; int lim;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  // reference model state
  int m_pos, m_vel, m_vv, m_st, m_ill, m_lim, m_win, m_acc, m_seen, m_stall;

  function automatic int sx(input int v);
    logic [PW-1:0] t;
    t = PW'(v);
    return int'($signed(t));
  endfunction

  function automatic void add(input bit cw, input bit ccw, input bit ld, input int ldv,
                              input int pos, input int st, input int ill,
                              input int vel, input int vv);
    vec_t v;
    v.cw = cw; v.ccw = ccw; v.ld = ld; v.ldv = ldv;
    v.pos = pos; v.st = st; v.ill = ill; v.vel = vel; v.vv = vv;
    tbl.push_back(v);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic model_step(input bit rst, input bit cw, input bit ccw, input bit ld, input int ldv);
    int step, np, s, seen_now;
    if (rst) begin
      m_pos = 0; m_vel = 0; m_vv = 0; m_st = 0; m_ill = 0; m_lim = 0;
      m_win = 0; m_acc = 0; m_seen = 0; m_stall = 0;
      return;
    end
    step = (cw && !ccw) ? 1 : ((ccw && !cw) ? -1 : 0);
    if (ld) m_pos = sx(ldv);
    else if (step != 0) begin
      np = m_pos + step;
      if (SAT) begin
        if (np <= PMAX && np >= PMIN) m_pos = np;
      end else begin
        m_pos = sx(np);
      end
    end
    m_lim = (SAT && (m_pos == PMAX || m_pos == PMIN)) ? 1 : 0;
    m_ill = (cw && ccw) ? 1 : 0;
    s = m_acc + step;
    if (s > 127) s = 127;
    if (s < -128) s = -128;
    seen_now = (m_seen != 0 || step != 0) ? 1 : 0;
    if (m_win == WIN - 1) begin
      m_vel = s; m_vv = 1; m_acc = 0; m_win = 0; m_seen = 0;
      if (seen_now != 0 || (m_st != 1 && m_st != 2)) m_stall = 0;
      else begin
        m_stall++;
        if (m_stall == SW) begin m_stall = 0; m_st = 3; end
      end
    end else begin
      m_acc = s; m_vv = 0; m_win++; m_seen = seen_now;
    end
    if (step > 0) m_st = 1;
    else if (step < 0) m_st = 2;
  endtask

  task automatic cycle(input bit rst, input bit cw, input bit ccw, input bit ld, input int ldv);
    exp_t e;
    reset = rst; is_cw = cw; is_ccw = ccw; load = ld; load_value = PW'(ldv);
    model_step(rst, cw, ccw, ld, ldv);
    e.pos = m_pos; e.vel = m_vel; e.vv = m_vv; e.st = m_st; e.ill = m_ill; e.lim = m_lim;
    sb.push_back(e);
    @(posedge clock);
    #1;
    e = sb.pop_front();
    chk("sb position", int'($signed(position)), e.pos);
    chk("sb velocity", int'($signed(velocity)), e.vel);
    chk("sb vel_valid", int'(vel_valid), e.vv);
    chk("sb state", int'(state), e.st);
    chk("sb illegal", int'(illegal), e.ill);
    chk("sb at_limit", int'(at_limit), e.lim);
    $display("cyc rst=%0b cw=%0b ccw=%0b ld=%0b pos=%0d vel=%0d vv=%0b st=%0d ill=%0b lim=%0b",
             rst, cw, ccw, ld, $signed(position), $signed(velocity), vel_valid, state,
             illegal, at_limit);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; is_cw = 1'b0; is_ccw = 1'b0; load = 1'b0; load_value = '0;

    // Hand-derived expectations: {cw, ccw, ld, ldv, pos, state, illegal, velocity, vel_valid}
    for (int i = 0; i < 5; i++) add(H, L, L, 0, i + 1, 1, 0, 0, 0);
    add(L, H, L, 0, 4, 2, 0, 0, 0);
    add(L, H, L, 0, 3, 2, 0, 0, 0);
    add(L, L, L, 0, 3, 2, 0, 0, 0);
    add(L, L, L, 0, 3, 2, 0, 0, 0);
    add(L, L, L, 0, 3, 2, 0, 3, 1);
    add(H, H, L, 0, 3, 2, 1, 3, 0);
    add(L, L, L, 0, 3, 2, 0, 3, 0);
    add(H, L, L, 0, 4, 1, 0, 3, 0);
    add(H, L, H, -20, -20, 1, 0, 3, 0);
    for (int i = 14; i < 19; i++) add(L, L, L, 0, -20, 1, 0, 3, 0);
    add(L, L, L, 0, -20, 1, 0, 2, 1);
    for (int i = 20; i < 29; i++) add(L, L, L, 0, -20, 1, 0, 2, 0);
    add(L, L, L, 0, -20, 1, 0, 0, 1);
    for (int i = 30; i < 39; i++) add(L, L, L, 0, -20, 1, 0, 0, 0);
    add(L, L, L, 0, -20, 3, 0, 0, 1);
    add(L, H, L, 0, -21, 2, 0, 0, 0);

    cycle(H, L, L, L, 0);
    chk("reset position", int'(position), 0);
    chk("reset state", int'(state), 0);
    chk("reset vel_valid", int'(vel_valid), 0);
    chk("reset illegal", int'(illegal), 0);

    foreach (tbl[i]) begin
      cycle(L, tbl[i].cw, tbl[i].ccw, tbl[i].ld, tbl[i].ldv);
      chk($sformatf("vec%0d position", i), int'($signed(position)), tbl[i].pos);
      chk($sformatf("vec%0d state", i), int'(state), tbl[i].st);
      chk($sformatf("vec%0d illegal", i), int'(illegal), tbl[i].ill);
      chk($sformatf("vec%0d velocity", i), int'($signed(velocity)), tbl[i].vel);
      chk($sformatf("vec%0d vel_valid", i), int'(vel_valid), tbl[i].vv);
    end

    // Positive bound: wrap or clamp, then step back down.
    cycle(L, L, L, H, 127);
    chk("limit load position", int'($signed(position)), 127);
    chk("limit load at_limit", int'(at_limit), SAT ? 1 : 0);
    cycle(L, H, L, L, 0);
    chk("limit cw position", int'($signed(position)), SAT ? 127 : -128);
    chk("limit cw at_limit", int'(at_limit), SAT ? 1 : 0);
    cycle(L, L, H, L, 0);
    chk("limit ccw position", int'($signed(position)), SAT ? 126 : 127);
    chk("limit ccw at_limit", int'(at_limit), 0);

    // Reset overrides a simultaneous load and step.
    cycle(H, H, L, H, 55);
    chk("rst>load position", int'($signed(position)), 0);
    chk("rst>load state", int'(state), 0);
    chk("rst>load velocity", int'($signed(velocity)), 0);
    cycle(L, L, L, L, 0);
    chk("post-reset position", int'($signed(position)), 0);
    chk("post-reset state", int'(state), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
